// File: rtl/mux_5to1_st.sv
// 5:1 lane multiplexer built as a tree of 2:1 cells, with a combinational output
// and registered copies of the result and the select-error flag.

module mux2_cell #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] out
);
  assign out = sel ? b : a;
endmodule

module mux_5to1_st #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5*DATA_W-1:0]   I,
  input  logic [2:0]            S,
  output logic [DATA_W-1:0]     Y,
  output logic                  sel_err,
  output logic [DATA_W-1:0]     Y_q,
  output logic                  sel_err_q
);
  localparam logic [DATA_W-1:0] ZERO = '0;

  logic [DATA_W-1:0] lo01;
  logic [DATA_W-1:0] lo23;
  logic [DATA_W-1:0] low4;
  logic [DATA_W-1:0] hi;

  mux2_cell #(.DATA_W(DATA_W)) u_l1_01 (
    .a   (I[0*DATA_W +: DATA_W]),
    .b   (I[1*DATA_W +: DATA_W]),
    .sel (S[0]),
    .out (lo01)
  );

  mux2_cell #(.DATA_W(DATA_W)) u_l1_23 (
    .a   (I[2*DATA_W +: DATA_W]),
    .b   (I[3*DATA_W +: DATA_W]),
    .sel (S[0]),
    .out (lo23)
  );

  mux2_cell #(.DATA_W(DATA_W)) u_l2 (
    .a   (lo01),
    .b   (lo23),
    .sel (S[1]),
    .out (low4)
  );

  // Lane 4 only survives for S=4; codes 5..7 fall through to the zero input.
  mux2_cell #(.DATA_W(DATA_W)) u_hi_gate (
    .a   (I[4*DATA_W +: DATA_W]),
    .b   (ZERO),
    .sel (S[1] | S[0]),
    .out (hi)
  );

  mux2_cell #(.DATA_W(DATA_W)) u_l3 (
    .a   (low4),
    .b   (hi),
    .sel (S[2]),
    .out (Y)
  );

  assign sel_err = S[2] & (S[1] | S[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y_q       <= '0;
      sel_err_q <= 1'b0;
    end else begin
      Y_q       <= Y;
      sel_err_q <= sel_err;
    end
  end
endmodule

// File: tb/tb_mux_5to1_st.sv
// Self-checking bench for mux_5to1_st: a 1-bit instance for the directed plan and a
// 4-bit instance that shares the select, checked against a scoreboard of expected results.

module tb_mux_5to1_st;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  I   = '0;
  logic [2:0]  S   = '0;
  logic        Y, sel_err, Y_q, sel_err_q;
  logic [19:0] I4  = '0;
  logic [3:0]  Y4, Y4_q;
  logic        sel_err4, sel_err4_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       y;
    logic       err;
    logic [3:0] yw;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];

  mux_5to1_st #(.DATA_W(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .I         (I),
    .S         (S),
    .Y         (Y),
    .sel_err   (sel_err),
    .Y_q       (Y_q),
    .sel_err_q (sel_err_q)
  );

  mux_5to1_st #(.DATA_W(4)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .I         (I4),
    .S         (S),
    .Y         (Y4),
    .sel_err   (sel_err4),
    .Y_q       (Y4_q),
    .sel_err_q (sel_err4_q)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [4:0] i, input logic [19:0] iw, input logic [2:0] s);
    exp_t e;
    e.err = (s > 3'd4);
    e.y   = e.err ? 1'b0 : i[s];
    e.yw  = e.err ? 4'h0 : iw[s*4 +: 4];
    return e;
  endfunction

  task automatic check_bits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives both DUTs and records what the combinational and registered paths should show.
  task automatic apply_stimulus(input logic [4:0] i, input logic [2:0] s);
    exp_t e;
    I  = i;
    S  = s;
    I4 = 20'($urandom);
    e  = model(i, I4, s);
    comb_q.push_back(e);
    reg_q.push_back(e);
  endtask

  task automatic check_output(input string tag, input int settle);
    exp_t e;
    #settle;
    if (comb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = comb_q.pop_front();
      check_bits({tag, ".Y"},        8'(Y),        8'(e.y));
      check_bits({tag, ".sel_err"},  8'(sel_err),  8'(e.err));
      check_bits({tag, ".Y4"},       8'(Y4),       8'(e.yw));
      check_bits({tag, ".sel_err4"}, 8'(sel_err4), 8'(e.err));
    end
  endtask

  task automatic check_registered(input string tag);
    exp_t e;
    if (reg_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = reg_q.pop_front();
      check_bits({tag, ".Y_q"},        8'(Y_q),        8'(e.y));
      check_bits({tag, ".sel_err_q"},  8'(sel_err_q),  8'(e.err));
      check_bits({tag, ".Y4_q"},       8'(Y4_q),       8'(e.yw));
      check_bits({tag, ".sel_err4_q"}, 8'(sel_err4_q), 8'(e.err));
    end
  endtask

  initial begin
    $display("[TB] start");

    // Load a known 1 into the registers, then reset asynchronously between edges.
    @(negedge clk);
    apply_stimulus(5'b11111, 3'd0);
    check_output("pre_reset", 1);
    @(posedge clk); #1;
    check_registered("pre_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_bits("async_rst.Y_q",        8'(Y_q),        8'h00);
    check_bits("async_rst.sel_err_q",  8'(sel_err_q),  8'h00);
    check_bits("async_rst.Y4_q",       8'(Y4_q),       8'h00);
    check_bits("async_rst.Y_live",     8'(Y),          8'h01);
    @(posedge clk); #1;
    check_bits("rst_hold.Y_q",         8'(Y_q),        8'h00);

    // Release and load lane 2, then an out-of-range code.
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(5'b00100, 3'd2);
    check_output("reg_s2", 1);
    @(posedge clk); #1;
    check_registered("reg_s2");
    check_bits("reg_s2.Y_q_const", 8'(Y_q), 8'h01);
    @(negedge clk);
    apply_stimulus(5'b00100, 3'd7);
    check_output("reg_s7", 1);
    @(posedge clk); #1;
    check_registered("reg_s7");
    check_bits("reg_s7.err_q_const", 8'(sel_err_q), 8'h01);

    // Mid-operation reset clears only the registered copies.
    @(negedge clk);
    apply_stimulus(5'b00100, 3'd2);
    check_output("mid_pre", 1);
    @(posedge clk); #1;
    check_registered("mid_pre");
    #2;
    rst = 1'b1;
    #1;
    check_bits("mid_rst.Y_q", 8'(Y_q), 8'h00);
    check_bits("mid_rst.Y",   8'(Y),   8'h01);
    apply_stimulus(5'b00100, 3'd5);
    check_output("mid_rst_track", 1);
    void'(reg_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    reg_q.delete();

    // Directed combinational plan.
    for (int s = 0; s < 5; s++) begin
      apply_stimulus(5'b10110, 3'(s));
      check_output($sformatf("sel_%0d", s), 10);
    end
    check_bits("const_s4.Y", 8'(Y), 8'h01);
    for (int s = 5; s < 8; s++) begin
      apply_stimulus(5'b11111, 3'(s));
      check_output($sformatf("oor_%0d", s), 10);
      check_bits($sformatf("oor_%0d.Y_const", s), 8'(Y), 8'h00);
    end
    apply_stimulus(5'b11111, 3'd4);
    check_output("back_s4", 10);
    apply_stimulus(5'b10000, 3'd4);
    check_output("gate_s4", 10);
    apply_stimulus(5'b10000, 3'd0);
    check_output("gate_s0", 10);
    apply_stimulus(5'b10000, 3'd6);
    check_output("gate_s6", 10);
    reg_q.delete();

    // Random regression across both paths.
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      apply_stimulus(5'($urandom), 3'($urandom_range(7)));
      check_output($sformatf("rand_%0d", n), 1);
      @(posedge clk); #1;
      check_registered($sformatf("rand_%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
